// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: read-after-write stall and branch-flush control for the
// five-stage pipeline. A shadow scoreboard tracks destination registers in
// flight between ID and register-file write; the pipeline has no forwarding.
module pipe_hazard_ctrl #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ADDR_W       = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [ADDR_W-1:0] id_wr_addr,
  input  logic              br_taken,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [DEPTH-1:0]  busy_mask,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        fcnt;
  logic [1:0]        fcnt_nxt;

  logic [DEPTH-1:0]  slot_vld;
  logic [ADDR_W-1:0] slot_addr [DEPTH];

  logic              rs_match;
  logic              rt_match;
  logic              rs_hit;
  logic              rt_hit;
  logic              hz;
  logic              slot_load;

  // Compare both ID sources against every valid in-flight destination.
  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && (slot_addr[i] == id_rs)) rs_match = 1'b1;
      if (slot_vld[i] && (slot_addr[i] == id_rt)) rt_match = 1'b1;
    end
    rs_hit = rs_match && id_rs_used && (id_rs != '0);
    rt_hit = rt_match && id_rt_used && (id_rt != '0);
    hz     = id_valid && (rs_hit || rt_hit);
  end

  // Flush wins over stall; all control outputs are forced low during reset
  // so a branch input held high while RST is asserted cannot leak through.
  always_comb begin
    flush_if_id  = !RST && (br_taken || ((state == FLUSH) && (fcnt != '0)));
    stall_if_id  = !RST && hz && !flush_if_id;
    bubble_id_ex = stall_if_id || flush_if_id;
    slot_load    = id_valid && id_wr_en && (id_wr_addr != '0) &&
                   !stall_if_id && !flush_if_id;
  end

  // Next-state logic: a taken branch from any state (re)starts the flush count.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (br_taken) begin
      state_nxt = FLUSH;
      fcnt_nxt  = FCNT_INIT;
    end else begin
      case (state)
        RUN: begin
          if (hz) state_nxt = STALL;
        end
        STALL: begin
          if (!hz) state_nxt = RUN;
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state_nxt = RUN;
          end else begin
            fcnt_nxt = fcnt - 2'd1;
          end
        end
        default: begin
          state_nxt = RUN;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // State register for the control FSM and its flush counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Shadow scoreboard: shifts every cycle, slot 0 takes the issuing ID write
  // or a bubble; the oldest slot falls off at register-file write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_addr[i] <= '0;
      end
    end else begin
      slot_vld[0]  <= slot_load;
      slot_addr[0] <= slot_load ? id_wr_addr : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slot_vld[i]  <= slot_vld[i-1];
        slot_addr[i] <= slot_addr[i-1];
      end
    end
  end

  assign busy_mask = slot_vld;

  // Saturating count of cycles spent stalling ID.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (stall_if_id && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (DEPTH=3, FLUSH_CYCLES=2).
// The reference model tracks the issue cycle of the latest write to each
// register instead of a shift register of slots.
module tb_pipe_hazard_ctrl;

  localparam int D  = 3;
  localparam int FC = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         id_valid;
  logic [4:0]   id_rs;
  logic [4:0]   id_rt;
  logic         id_rs_used;
  logic         id_rt_used;
  logic         id_wr_en;
  logic [4:0]   id_wr_addr;
  logic         br_taken;
  logic         stall_if_id;
  logic         bubble_id_ex;
  logic         flush_if_id;
  logic [D-1:0] busy_mask;
  logic [15:0]  stall_cnt;

  pipe_hazard_ctrl #(
    .DEPTH(D),
    .FLUSH_CYCLES(FC),
    .ADDR_W(5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .id_valid(id_valid),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr),
    .br_taken(br_taken),
    .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id),
    .busy_mask(busy_mask),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         stall;
    logic         bubble;
    logic         flush;
    logic [D-1:0] busy;
    logic [15:0]  cnt;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;

  int           cyc;
  int           last_wr[32];
  int           issues[$];
  int           rem;
  logic [15:0]  mcnt;

  logic         last_stall;
  logic         last_bubble;
  logic         last_flush;
  logic [D-1:0] last_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) last_wr[r] = -1000;
    issues.delete();
    rem  = 0;
    mcnt = '0;
    cyc  = 0;
  endfunction

  // A write issued at cycle c occupies the scoreboard during cycles c+1..c+D.
  function automatic logic hit(input logic [4:0] r, input logic u);
    return u && (r != 5'd0) && (last_wr[r] >= cyc - D);
  endfunction

  function automatic exp_t predict(input logic v, input logic [4:0] rs, input logic rsu,
                                   input logic [4:0] rt, input logic rtu, input logic br);
    exp_t e;
    logic hz;
    hz       = v && (hit(rs, rsu) || hit(rt, rtu));
    e.flush  = br || (rem > 0);
    e.stall  = hz && !e.flush;
    e.bubble = e.stall || e.flush;
    e.busy   = '0;
    foreach (issues[k]) begin
      for (int i = 0; i < D; i++) begin
        if (issues[k] == cyc - 1 - i) e.busy[i] = 1'b1;
      end
    end
    e.cnt = mcnt;
    return e;
  endfunction

  function automatic void advance(input exp_t e, input logic v, input logic we,
                                  input logic [4:0] wa, input logic br);
    if (e.stall && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    if (v && we && wa != 5'd0 && !e.stall && !e.flush) begin
      last_wr[wa] = cyc;
      issues.push_back(cyc);
    end
    if (br) rem = FC - 1;
    else if (rem > 0) rem = rem - 1;
    cyc++;
    while (issues.size() > 0 && issues[0] < cyc - D) void'(issues.pop_front());
  endfunction

  // One pipeline cycle: drive, queue the prediction, compare at the falling edge.
  task automatic step(input logic v, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu, input logic we,
                      input logic [4:0] wa, input logic br);
    exp_t e;
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_wr_en   = we;
    id_wr_addr = wa;
    br_taken   = br;
    sb.push_back(predict(v, rs, rsu, rt, rtu, br));
    @(negedge CLK);
    e = sb.pop_front();
    check("stall",  32'(stall_if_id),  32'(e.stall));
    check("bubble", 32'(bubble_id_ex), 32'(e.bubble));
    check("flush",  32'(flush_if_id),  32'(e.flush));
    check("busy",   32'(busy_mask),    32'(e.busy));
    check("cnt",    32'(stall_cnt),    32'(e.cnt));
    last_stall  = stall_if_id;
    last_bubble = bubble_id_ex;
    last_flush  = flush_if_id;
    last_busy   = busy_mask;
    advance(e, v, we, wa, br);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST        = 1'b1;
    id_valid   = 1'b0;
    id_rs      = '0;
    id_rt      = '0;
    id_rs_used = 1'b0;
    id_rt_used = 1'b0;
    id_wr_en   = 1'b0;
    id_wr_addr = '0;
    br_taken   = 1'b1;
    model_reset();

    // Reset: outputs low even with a branch input held high.
    repeat (2) @(posedge CLK);
    #2;
    check("rst_stall",  32'(stall_if_id),  32'd0);
    check("rst_bubble", 32'(bubble_id_ex), 32'd0);
    check("rst_flush",  32'(flush_if_id),  32'd0);
    check("rst_busy",   32'(busy_mask),    32'd0);
    check("rst_cnt",    32'(stall_cnt),    32'd0);
    br_taken = 1'b0;
    release_reset();
    idle();

    // Back-to-back RAW on r5: three stall cycles, busy walks 001,010,100.
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("raw_s1", 32'(last_stall), 32'd1);
    check("raw_b1", 32'(last_busy),  32'b001);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("raw_s2", 32'(last_stall), 32'd1);
    check("raw_b2", 32'(last_busy),  32'b010);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("raw_s3", 32'(last_stall), 32'd1);
    check("raw_bub3", 32'(last_bubble), 32'd1);
    check("raw_b3", 32'(last_busy),  32'b100);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("raw_s4", 32'(last_stall), 32'd0);
    idle();
    check("raw_cnt", 32'(stall_cnt), 32'd3);

    // r0 never tracked, unused rt ignored, self source/dest not a hazard.
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("r0_stall", 32'(last_stall), 32'd0);
    check("r0_busy",  32'(last_busy),  32'd0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    step(1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rt_unused", 32'(last_stall), 32'd0);
    step(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    check("self_dep", 32'(last_stall), 32'd0);
    repeat (4) idle();

    // Branch while a hazard is pending: flush wins for two cycles, no entry.
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    step(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
    check("br_f1", 32'(last_flush),  32'd1);
    check("br_s1", 32'(last_stall),  32'd0);
    check("br_b1", 32'(last_bubble), 32'd1);
    step(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    check("br_f2", 32'(last_flush),  32'd1);
    check("br_s2", 32'(last_stall),  32'd0);
    check("br_b2", 32'(last_bubble), 32'd1);
    step(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    check("br_f3",   32'(last_flush), 32'd0);
    check("br_busy", 32'(last_busy),  32'b100);
    repeat (2) step(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    repeat (4) idle();

    // A second branch during flush restarts the count.
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rebr_f3", 32'(last_flush), 32'd1);
    idle();
    check("rebr_f4", 32'(last_flush), 32'd0);

    // Reset during a stall clears everything without a clock edge.
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("pre_rst_stall", 32'(stall_if_id), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("midrst_stall",  32'(stall_if_id),  32'd0);
    check("midrst_bubble", 32'(bubble_id_ex), 32'd0);
    check("midrst_busy",   32'(busy_mask),    32'd0);
    check("midrst_cnt",    32'(stall_cnt),    32'd0);
    release_reset();
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("postrst_stall", 32'(last_stall), 32'd0);

    // Saturation: an instruction reading and writing r5 re-hazards itself.
    repeat (87400) step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    repeat (20) step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
